// File: rtl/sincos_arb.sv
// Round-robin front end for a shared sincos core: grants one requester per cycle,
// tracks ownership through a tag pipeline aligned with the core, and routes results back.
module sincos_arb #(
    parameter int N_REQ = 4,
    parameter int LAT   = 16,
    parameter int W     = 27
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_angle,
    output logic [N_REQ-1:0]   req_ready,
    output logic               core_en,
    output logic [W-1:0]       core_angle,
    input  logic [W-1:0]       core_sin,
    input  logic [W-1:0]       core_cos,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_sin,
    output logic [W-1:0]       rsp_cos,
    output logic               busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic              run;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              grant_any;
    logic [PW-1:0]     grant_id;
    logic [W-1:0]      angle_arr [N_REQ];
    logic [W-1:0]      core_angle_q;
    logic [LAT:0]      tag_v_q;
    logic [PW-1:0]     tag_id_q [LAT+1];
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [W-1:0]      rsp_sin_q, rsp_cos_q;

    assign run = enable & ~reset;

    // Walk from ptr upward; descending scan so the earliest match wins the overwrite.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = PW'(idx);
            end
        end
    end

    assign ptr_d = (grant_id == PW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign angle_arr[gi]   = req_angle[gi*W +: W];
            assign req_ready[gi]   = run & grant_any & (grant_id == PW'(gi));
            assign rsp_valid_d[gi] = tag_v_q[LAT] & (tag_id_q[LAT] == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            core_angle_q <= '0;
            tag_v_q      <= '0;
            for (int s = 0; s <= LAT; s++) tag_id_q[s] <= '0;
            rsp_valid_q  <= '0;
            rsp_sin_q    <= '0;
            rsp_cos_q    <= '0;
        end else if (enable) begin
            if (grant_any) begin
                ptr_q        <= ptr_d;
                core_angle_q <= angle_arr[grant_id];
            end
            // Bubbles enter as valid=0 so tags stay lock-step with the core.
            tag_v_q     <= {tag_v_q[LAT-1:0], grant_any};
            tag_id_q[0] <= grant_id;
            for (int s = 1; s <= LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
            rsp_valid_q <= rsp_valid_d;
            if (tag_v_q[LAT]) begin
                rsp_sin_q <= core_sin;
                rsp_cos_q <= core_cos;
            end
        end else begin
            rsp_valid_q <= '0;
        end
    end

    assign core_en    = run;
    assign core_angle = core_angle_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_sin    = rsp_sin_q;
    assign rsp_cos    = rsp_cos_q;
    assign busy       = (|tag_v_q) | (|rsp_valid_q);

endmodule
